// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, function codes,
// ALU control values and the sequencer state enum.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned ALUCTR_W = 4;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNC_W-1:0] FN_XOR = 6'b100110;
  localparam logic [FUNC_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FUNC_W-1:0] FN_SRL = 6'b000010;
  localparam logic [FUNC_W-1:0] FN_SRA = 6'b000011;
  localparam logic [FUNC_W-1:0] FN_JR  = 6'b001000;

  localparam logic [ALUCTR_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUCTR_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALUCTR_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALUCTR_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALUCTR_W-1:0] ALU_XOR = 4'b0100;
  localparam logic [ALUCTR_W-1:0] ALU_SLL = 4'b0101;
  localparam logic [ALUCTR_W-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALUCTR_W-1:0] ALU_SRA = 4'b0111;
  localparam logic [ALUCTR_W-1:0] ALU_LUI = 4'b1000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational (op, func) -> ALU control, operand select, extension mode and
// legality. Sequencing is handled entirely by the FSM in the top.
module alu_op_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     op,
  input  logic [FUNC_W-1:0]   func,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                alu_src,
  output logic                ext_op,
  output logic                legal
);

  always_comb begin
    alu_ctr = ALU_ADD;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    legal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        legal = 1'b1;
        case (func)
          FN_ADD:  alu_ctr = ALU_ADD;
          FN_SUB:  alu_ctr = ALU_SUB;
          FN_AND:  alu_ctr = ALU_AND;
          FN_OR:   alu_ctr = ALU_OR;
          FN_XOR:  alu_ctr = ALU_XOR;
          FN_SLL:  alu_ctr = ALU_SLL;
          FN_SRL:  alu_ctr = ALU_SRL;
          FN_SRA:  alu_ctr = ALU_SRA;
          FN_JR:   alu_ctr = ALU_ADD;
          default: legal   = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        legal   = 1'b1;
        alu_ctr = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = 1'b1;
      end
      OP_ANDI: begin legal = 1'b1; alu_ctr = ALU_AND; alu_src = 1'b1; end
      OP_ORI:  begin legal = 1'b1; alu_ctr = ALU_OR;  alu_src = 1'b1; end
      OP_XORI: begin legal = 1'b1; alu_ctr = ALU_XOR; alu_src = 1'b1; end
      OP_LUI:  begin legal = 1'b1; alu_ctr = ALU_LUI; alu_src = 1'b1; end
      // Branches compare rs against rt, so the immediate only feeds the target adder
      OP_BEQ, OP_BNE: begin
        legal   = 1'b1;
        alu_ctr = ALU_SUB;
        ext_op  = 1'b1;
      end
      OP_J, OP_JAL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ack memory
// handshakes. Define ILLEGAL_TRAP_EN to trap on unknown encodings instead of treating them as NOPs.
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNC_W-1:0]   func,
  input  logic                i_ack,
  input  logic                d_ack,
  input  logic                zero,
  output logic                i_req,
  output logic                d_req,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic                ALUSrc,
  output logic                Extop,
  output logic [1:0]          RegDst,
  output logic [1:0]          MemtoReg,
  output logic                RegWr,
  output logic                MemWr,
  output logic                Branch_eq,
  output logic                Branch_ne,
  output logic [1:0]          Jump,
  output logic                trap
);

  state_t              state;
  state_t              state_d;
  logic [OP_W-1:0]     op_q;
  logic [FUNC_W-1:0]   func_q;
  logic [ALUCTR_W-1:0] dec_ctr;
  logic                dec_src;
  logic                dec_ext;
  logic                legal;
  logic                unused_zero;

  // Branch outcome is resolved in the datapath; the flag is not needed here
  assign unused_zero = zero;

  alu_op_decoder u_dec (
    .op      (op_q),
    .func    (func_q),
    .alu_ctr (dec_ctr),
    .alu_src (dec_src),
    .ext_op  (dec_ext),
    .legal   (legal)
  );

  logic is_r, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw;
  assign is_r   = (op_q == OP_RTYPE);
  assign is_jr  = is_r && (func_q == FN_JR);
  assign is_j   = (op_q == OP_J);
  assign is_jal = (op_q == OP_JAL);
  assign is_beq = (op_q == OP_BEQ);
  assign is_bne = (op_q == OP_BNE);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);

  // IR loads only when a live fetch request is acknowledged
  assign ir_wr = (state == FETCH) && i_req && i_ack;

  always_comb begin
    state_d = state;
    case (state)
      FETCH:  if (ir_wr) state_d = DECODE;
      DECODE: begin
        if (is_j || is_jal || is_jr) state_d = FETCH;
        else if (!legal)
`ifdef ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          state_d = FETCH;
`endif
        else state_d = EXEC;
      end
      EXEC: begin
        if (is_beq || is_bne)    state_d = FETCH;
        else if (is_lw || is_sw) state_d = MEM;
        else                     state_d = WB;
      end
      MEM:     if (d_req && d_ack) state_d = is_lw ? WB : FETCH;
      WB:      state_d = FETCH;
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // State, IR field latch and the held handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      op_q   <= '0;
      func_q <= '0;
      i_req  <= 1'b0;
      d_req  <= 1'b0;
      MemWr  <= 1'b0;
    end else begin
      state <= state_d;
      i_req <= (state_d == FETCH);
      d_req <= (state_d == MEM);
      MemWr <= (state_d == MEM) && is_sw;
      if (ir_wr) begin
        op_q   <= op;
        func_q <= func;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap <= 1'b0;
    else        trap <= (state_d == TRAP);
  end
`else
  assign trap = 1'b0;
`endif

  // Per-state datapath strobes, decoded from the state register and latched IR fields
  always_comb begin
    pc_wr     = 1'b0;
    ALUctr    = '0;
    ALUSrc    = 1'b0;
    Extop     = 1'b0;
    RegDst    = 2'b00;
    MemtoReg  = 2'b00;
    RegWr     = 1'b0;
    Branch_eq = 1'b0;
    Branch_ne = 1'b0;
    Jump      = 2'b00;
    case (state)
      FETCH: pc_wr = ir_wr;
      DECODE: begin
        if (is_j || is_jal) begin
          Jump  = 2'b01;
          pc_wr = 1'b1;
        end
        if (is_jal) begin
          RegWr    = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        if (is_jr) begin
          Jump  = 2'b10;
          pc_wr = 1'b1;
        end
      end
      EXEC: begin
        ALUctr    = dec_ctr;
        ALUSrc    = dec_src;
        Extop     = dec_ext;
        Branch_eq = is_beq;
        Branch_ne = is_bne;
        pc_wr     = is_beq || is_bne;
      end
      MEM: begin
        ALUctr = dec_ctr;
        ALUSrc = dec_src;
        Extop  = dec_ext;
      end
      WB: begin
        RegWr    = 1'b1;
        RegDst   = is_r ? 2'b01 : 2'b00;
        MemtoReg = is_lw ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: latency/decode table, hand-written
// reset and wait-state sequences, and randomized instruction streams against a trace model.
module tb_multicycle_control_unit;

  localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] XORI = 6'b001110, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, LUI = 6'b001111, J = 6'b000010, JAL = 6'b000011;
  localparam int K_ILL = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_BEQ = 4, K_BNE = 5;
  localparam int K_LW = 6, K_SW = 7, K_RALU = 8, K_IALU = 9;

  logic clk = 1'b0, rst_n = 1'b1, i_ack = 1'b0, d_ack = 1'b0, zero = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic i_req, d_req, ir_wr, pc_wr, ALUSrc, Extop, RegWr, MemWr, Branch_eq, Branch_ne, trap;
  logic [3:0] ALUctr;
  logic [1:0] RegDst, MemtoReg, Jump;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .i_ack(i_ack), .d_ack(d_ack), .zero(zero),
    .i_req(i_req), .d_req(d_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .ALUctr(ALUctr), .ALUSrc(ALUSrc),
    .Extop(Extop), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWr(RegWr), .MemWr(MemWr),
    .Branch_eq(Branch_eq), .Branch_ne(Branch_ne), .Jump(Jump), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic i_req, d_req, ir_wr, pc_wr;
    logic [3:0] alu_ctr;
    logic alu_src, ext_op;
    logic [1:0] reg_dst, mem_to_reg;
    logic reg_wr, mem_wr, br_eq, br_ne;
    logic [1:0] jump;
    logic trap;
  } outs_t;

  typedef struct {
    logic i_ack, d_ack, junk_ok;
    outs_t o;
  } step_t;

  typedef struct {
    logic [5:0] op, func;
    int lat;
    logic [3:0] ctr;
    logic ext;
  } vec_t;

  int n_cmp = 0, n_bad = 0;

  function automatic outs_t cur_outs();
    outs_t a;
    a.i_req = i_req; a.d_req = d_req; a.ir_wr = ir_wr; a.pc_wr = pc_wr;
    a.alu_ctr = ALUctr; a.alu_src = ALUSrc; a.ext_op = Extop;
    a.reg_dst = RegDst; a.mem_to_reg = MemtoReg; a.reg_wr = RegWr; a.mem_wr = MemWr;
    a.br_eq = Branch_eq; a.br_ne = Branch_ne; a.jump = Jump; a.trap = trap;
    return a;
  endfunction

  task automatic check_outs(input outs_t want, input string tag);
    outs_t got;
    got = cur_outs();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: outputs got %h want %h", tag, got, want);
    end
  endtask

  task automatic check_int(input int got, input int want, input string tag);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Instruction classification straight from the ISA tables
  function automatic void ref_dec(input logic [5:0] o, input logic [5:0] f, output int kind,
                                  output logic [3:0] ctr, output logic src, output logic ext);
    kind = K_ILL; ctr = 4'd0; src = 1'b0; ext = 1'b0;
    case (o)
      R: begin
        kind = K_RALU;
        case (f)
          6'b100000: ctr = 4'd0;
          6'b100010: ctr = 4'd1;
          6'b100100: ctr = 4'd2;
          6'b100101: ctr = 4'd3;
          6'b100110: ctr = 4'd4;
          6'b000000: ctr = 4'd5;
          6'b000010: ctr = 4'd6;
          6'b000011: ctr = 4'd7;
          6'b001000: kind = K_JR;
          default:   kind = K_ILL;
        endcase
      end
      ADDI: begin kind = K_IALU; ctr = 4'd0; src = 1'b1; ext = 1'b1; end
      ANDI: begin kind = K_IALU; ctr = 4'd2; src = 1'b1; end
      ORI:  begin kind = K_IALU; ctr = 4'd3; src = 1'b1; end
      XORI: begin kind = K_IALU; ctr = 4'd4; src = 1'b1; end
      LUI:  begin kind = K_IALU; ctr = 4'd8; src = 1'b1; end
      LW:   begin kind = K_LW;   ctr = 4'd0; src = 1'b1; ext = 1'b1; end
      SW:   begin kind = K_SW;   ctr = 4'd0; src = 1'b1; ext = 1'b1; end
      BEQ:  begin kind = K_BEQ;  ctr = 4'd1; ext = 1'b1; end
      BNE:  begin kind = K_BNE;  ctr = 4'd1; ext = 1'b1; end
      J:    kind = K_J;
      JAL:  kind = K_JAL;
      default: kind = K_ILL;
    endcase
  endfunction

  function automatic step_t spurious(input logic junk);
    step_t s;
    s.i_ack = 1'($urandom); s.d_ack = 1'($urandom); s.junk_ok = junk; s.o = '0;
    return s;
  endfunction

  // Build the expected per-cycle trace of one instruction, then drive and compare it
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int iw, input int dw,
                           input string tag);
    step_t tr[$];
    step_t s;
    int kind;
    logic [3:0] ctr;
    logic src, ext;
    ref_dec(o, f, kind, ctr, src, ext);
    for (int w = 0; w < iw; w++) begin
      s = spurious(1'b0); s.i_ack = 1'b0; s.o.i_req = 1'b1; tr.push_back(s);
    end
    s = spurious(1'b0); s.i_ack = 1'b1; s.o.i_req = 1'b1; s.o.ir_wr = 1'b1; s.o.pc_wr = 1'b1;
    tr.push_back(s);
    s = spurious(1'b0);
    if (kind == K_J || kind == K_JAL) begin s.o.jump = 2'b01; s.o.pc_wr = 1'b1; end
    if (kind == K_JAL) begin s.o.reg_wr = 1'b1; s.o.reg_dst = 2'b10; s.o.mem_to_reg = 2'b10; end
    if (kind == K_JR) begin s.o.jump = 2'b10; s.o.pc_wr = 1'b1; end
    tr.push_back(s);
    if (kind == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      for (int t = 0; t < 5; t++) begin s = spurious(1'b1); s.o.trap = 1'b1; tr.push_back(s); end
`endif
    end else if (kind != K_J && kind != K_JAL && kind != K_JR) begin
      s = spurious(1'b1);
      s.o.alu_ctr = ctr; s.o.alu_src = src; s.o.ext_op = ext;
      s.o.br_eq = (kind == K_BEQ); s.o.br_ne = (kind == K_BNE);
      s.o.pc_wr = (kind == K_BEQ || kind == K_BNE);
      tr.push_back(s);
      if (kind == K_LW || kind == K_SW) begin
        for (int w = 0; w <= dw; w++) begin
          s = spurious(1'b1); s.d_ack = (w == dw);
          s.o.d_req = 1'b1; s.o.mem_wr = (kind == K_SW);
          s.o.alu_ctr = ctr; s.o.alu_src = src; s.o.ext_op = ext;
          tr.push_back(s);
        end
      end
      if (kind == K_LW || kind == K_RALU || kind == K_IALU) begin
        s = spurious(1'b1); s.o.reg_wr = 1'b1;
        s.o.reg_dst = (kind == K_RALU) ? 2'b01 : 2'b00;
        s.o.mem_to_reg = (kind == K_LW) ? 2'b01 : 2'b00;
        tr.push_back(s);
      end
    end
    foreach (tr[k]) begin
      @(negedge clk);
      i_ack = tr[k].i_ack; d_ack = tr[k].d_ack; zero = 1'($urandom);
      if (tr[k].junk_ok) begin op = 6'($urandom); func = 6'($urandom); end
      else begin op = o; func = f; end
      #1 check_outs(tr[k].o, $sformatf("%s cyc%0d", tag, k));
    end
  endtask

  // Responsive memories: count cycles until the next fetch request, OR-ing ALU fields
  task automatic measure(input logic [5:0] o, input logic [5:0] f, output int lat,
                         output logic [3:0] ctr_or, output logic ext_or);
    bit done = 0;
    lat = 0; ctr_or = '0; ext_or = 1'b0; op = o; func = f;
    while (!done) begin
      @(negedge clk); #1;
      if (lat > 0 && i_req) done = 1;
      else if (lat > 30) begin
        n_cmp++; n_bad++;
        $display("FAIL measure_timeout: op %b no fetch after %0d cycles", o, lat);
        done = 1;
      end else begin
        i_ack = i_req; d_ack = d_req; lat++;
        ctr_or |= ALUctr; ext_or |= Extop;
      end
    end
    i_ack = 1'b0; d_ack = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst_n = 1'b0; i_ack = 1'($urandom); d_ack = 1'($urandom);
    #1 check_outs('0, {tag, " assert"});
    repeat (2) @(negedge clk);
    #1 check_outs('0, {tag, " held"});
    @(negedge clk); rst_n = 1'b1; i_ack = 1'b0; d_ack = 1'b0;
    #1 check_outs('0, {tag, " released"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[14];
    int lat;
    logic [3:0] ctr_or;
    logic ext_or;
    logic [5:0] pool_op[$], pool_fn[$];
    logic [5:0] fn_list[9];
    outs_t w;

    vt[0]  = '{R,    6'b100000, 4, 4'd0, 1'b0};
    vt[1]  = '{R,    6'b100010, 4, 4'd1, 1'b0};
    vt[2]  = '{R,    6'b000000, 4, 4'd5, 1'b0};
    vt[3]  = '{R,    6'b000011, 4, 4'd7, 1'b0};
    vt[4]  = '{ADDI, 6'b010101, 4, 4'd0, 1'b1};
    vt[5]  = '{ORI,  6'b000000, 4, 4'd3, 1'b0};
    vt[6]  = '{LUI,  6'b111000, 4, 4'd8, 1'b0};
    vt[7]  = '{LW,   6'b000001, 5, 4'd0, 1'b1};
    vt[8]  = '{SW,   6'b000001, 4, 4'd0, 1'b1};
    vt[9]  = '{BEQ,  6'b000000, 3, 4'd1, 1'b1};
    vt[10] = '{BNE,  6'b000000, 3, 4'd1, 1'b1};
    vt[11] = '{J,    6'b001000, 2, 4'd0, 1'b0};
    vt[12] = '{JAL,  6'b000000, 2, 4'd0, 1'b0};
    vt[13] = '{R,    6'b001000, 2, 4'd0, 1'b0};

    do_reset("reset");

    foreach (vt[i]) begin
      measure(vt[i].op, vt[i].func, lat, ctr_or, ext_or);
      check_int(lat, vt[i].lat, $sformatf("latency op%b fn%b", vt[i].op, vt[i].func));
      check_int(int'({ctr_or, ext_or}), int'({vt[i].ctr, vt[i].ext}),
                $sformatf("aluctr_extop op%b fn%b", vt[i].op, vt[i].func));
    end

    run_instr(R,   6'b100000, 0, 0, "add_zero_wait");
    run_instr(LW,  6'b000000, 0, 3, "lw_dwait3");
    run_instr(SW,  6'b000000, 2, 1, "sw_waits");
    run_instr(BEQ, 6'b000000, 0, 0, "beq");
    run_instr(JAL, 6'b000000, 1, 0, "jal");
    run_instr(R,   6'b001000, 0, 0, "jr");

    // Async reset while the data access is outstanding
    op = SW; func = '0;
    @(negedge clk); i_ack = 1'b1;
    #1 check_int(int'(ir_wr), 1, "rstmem fetch ir_wr");
    @(negedge clk); i_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check_int(int'({d_req, MemWr}), 3, "rstmem in_mem d_req_memwr");
    #1 rst_n = 1'b0; d_ack = 1'b1;
    #1 check_outs('0, "rstmem dropped");
    @(negedge clk); rst_n = 1'b1;
    #1 check_outs('0, "rstmem released");
    run_instr(ORI, 6'b000000, 0, 0, "after_rstmem");

`ifdef ILLEGAL_TRAP_EN
    run_instr(6'b111111, 6'b000000, 0, 0, "trap_op");
    do_reset("trap_op_reset");
    run_instr(R, 6'b111111, 1, 0, "trap_fn");
    do_reset("trap_fn_reset");
`else
    run_instr(6'b111111, 6'b000000, 0, 0, "nop_op");
    run_instr(R, 6'b111111, 1, 0, "nop_fn");
`endif
    w = '0; w.i_req = 1'b1;
    @(negedge clk); i_ack = 1'b0;
    #1 check_outs(w, "fetch_after_sequences");

    fn_list = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                6'b000000, 6'b000010, 6'b000011, 6'b001000};
    foreach (fn_list[i]) begin pool_op.push_back(R); pool_fn.push_back(fn_list[i]); end
    pool_op = {pool_op, ADDI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL};
    while (pool_fn.size() < pool_op.size()) pool_fn.push_back(6'h3f);
`ifndef ILLEGAL_TRAP_EN
    pool_op.push_back(6'b111111); pool_fn.push_back(6'b000000);
    pool_op.push_back(R);         pool_fn.push_back(6'b111111);
`endif

    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [5:0] f;
      sel = $urandom_range(0, pool_op.size() - 1);
      f = (pool_op[sel] == R) ? pool_fn[sel] : 6'($urandom);
      if (pool_op[sel] == R && pool_fn[sel] == 6'h3f) f = 6'h3f;
      run_instr(pool_op[sel], f, $urandom_range(0, 3), $urandom_range(0, 3),
                $sformatf("rand%0d op%b", n, pool_op[sel]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
